// File: rtl/poly_sub_ctrl.sv
// poly_sub_ctrl
//   Streams N coefficient pairs from the A/B polynomial memories through a
//   modular subtractor and writes the N results to the C memory.
//   One coefficient per clock; reports busy/done to the scheduler.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   start_i    : launch a vector operation (accepted in IDLE only)
//   abort_i    : cancel the operation in progress (RUN/DRAIN only)
//   q_i        : modulus, latched on an accepted start
//   rd_en_o    : read strobe shared by A and B memories
//   rd_addr_o  : read address shared by A and B memories
//   a_data_i   : A read data, valid one cycle after rd_en_o
//   b_data_i   : B read data, valid one cycle after rd_en_o
//   c_we_o     : C write enable
//   c_addr_o   : C write address
//   c_data_o   : C write data
//   busy_o     : high in RUN and DRAIN
//   done_o     : one-cycle completion pulse

// mod_sub: c = (a - b + (a < b ? q : 0)) mod 2^23, a/b compared on 24 bits.
module mod_sub (
    input  logic [23:0] a_i,
    input  logic [23:0] b_i,
    input  logic [22:0] q_i,
    output logic [22:0] c_o
);
    logic        w_borrow;
    logic [24:0] w_full;

    assign w_borrow = (a_i < b_i);
    assign w_full   = {1'b0, a_i} - {1'b0, b_i} + (w_borrow ? {2'b00, q_i} : '0);
    assign c_o      = 23'(w_full);
endmodule

module poly_sub_ctrl #(
    parameter int N  = 256,
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [22:0]   q_i,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    input  logic [23:0]   a_data_i,
    input  logic [23:0]   b_data_i,
    output logic          c_we_o,
    output logic [AW-1:0] c_addr_o,
    output logic [22:0]   c_data_o,
    output logic          busy_o,
    output logic          done_o
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_addr;      // address issued this cycle; holds when idle
    logic          r_drain;     // second DRAIN cycle marker
    logic [22:0]   r_q;
    logic          r_v1;        // read issued last cycle -> data on a/b inputs now
    logic [AW-1:0] r_addr1;
    logic          r_c_we;
    logic [AW-1:0] r_c_addr;
    logic [22:0]   r_c_data;
    logic          w_run;
    logic          w_abort;
    logic [22:0]   w_c;

    assign w_run   = (r_state == S_RUN);
    assign w_abort = abort_i && ((r_state == S_RUN) || (r_state == S_DRAIN));

    mod_sub u_mod_sub (
        .a_i (a_data_i),
        .b_i (b_data_i),
        .q_i (r_q),
        .c_o (w_c)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = S_RUN;
            S_RUN: begin
                if (abort_i)                  w_state_nxt = S_IDLE;
                else if (r_addr == LAST_ADDR) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort_i)      w_state_nxt = S_IDLE;
                else if (r_drain) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_drain  <= 1'b0;
            r_q      <= '0;
            r_v1     <= 1'b0;
            r_addr1  <= '0;
            r_c_we   <= 1'b0;
            r_c_addr <= '0;
            r_c_data <= '0;
        end else begin
            r_state <= w_state_nxt;

            if ((r_state == S_IDLE) && start_i) begin
                r_q    <= q_i;
                r_addr <= '0;
            end else if (w_run && !w_abort && (r_addr != LAST_ADDR)) begin
                r_addr <= r_addr + 1'b1;
            end

            r_drain <= (r_state == S_DRAIN) && !r_drain && !w_abort;

            // Abort kills both in-flight stages on the same edge.
            r_v1    <= w_run && !w_abort;
            r_addr1 <= r_addr;
            r_c_we  <= r_v1 && !w_abort;
            if (r_v1) begin
                r_c_addr <= r_addr1;
                r_c_data <= w_c;
            end
        end
    end

    assign rd_en_o   = w_run;
    assign rd_addr_o = r_addr;
    assign c_we_o    = r_c_we;
    assign c_addr_o  = r_c_addr;
    assign c_data_o  = r_c_data;
    assign busy_o    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done_o    = (r_state == S_DONE);
endmodule

// File: doc/poly_sub_ctrl.md
# poly_sub_ctrl

Sequencer that drives the combinational modular subtractor (`mod_sub`) across a whole coefficient vector. On `start_i` it streams N coefficient pairs from two synchronous-read memories, subtracts each pair modulo q, and writes N results to a third memory. It sits between the polynomial RAMs and the arithmetic datapath and reports `busy_o` and `done_o` to the top-level scheduler.

## Interface

Parameters:
- `N`, default 256: number of coefficients per vector; must be at least 2.
- `AW`, default 8: address width; requires 2^AW ≥ N.

Ports:
- `clk_i`, in, 1: single clock; all logic on the rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `start_i`, in, 1: launches a vector operation; honoured only in IDLE.
- `abort_i`, in, 1: cancels the operation in progress.
- `q_i`, in, 23: modulus; latched on an accepted start.
- `rd_en_o`, out, 1: read strobe shared by the A and B memories.
- `rd_addr_o`, out, AW: read address shared by the A and B memories.
- `a_data_i`, in, 24: A memory read data, valid 1 cycle after `rd_en_o`.
- `b_data_i`, in, 24: B memory read data, valid 1 cycle after `rd_en_o`.
- `c_we_o`, out, 1: C memory write enable.
- `c_addr_o`, out, AW: C memory write address.
- `c_data_o`, out, 23: C memory write data.
- `busy_o`, out, 1: operation in progress.
- `done_o`, out, 1: one-cycle completion pulse.

## Operation

- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start_i` = 1 latches `q_i` into `q_r`, clears the read counter, and moves to RUN.
  - `start_i` in any other state is ignored.
- RUN:
  - Every cycle: `rd_en_o` = 1, `rd_addr_o` = k, k increments.
  - After the cycle issuing k = N−1, moves to DRAIN.
- DRAIN: lasts exactly 2 cycles to flush the pipeline, then moves to DONE.
- DONE: lasts 1 cycle with `done_o` = 1 and `busy_o` = 0, then returns to IDLE.
- Pipeline:
  - Stage 1 is the memory read.
  - Stage 2 feeds `a_data_i`/`b_data_i` and `q_r` to an internal `mod_sub` instance.
  - The result, its address and a valid bit are registered into `c_data_o`/`c_addr_o`/`c_we_o`.
- Arithmetic:
  - c = (a − b + (a < b ? q : 0)) mod 2^23.
  - Compare a and b unsigned on 24 bits.
  - Compute in at least 25 bits, then truncate to the low 23 bits.
- `busy_o` = 1 in RUN and DRAIN, else 0.
- `abort_i` = 1 in RUN or DRAIN:
  - Next state is IDLE; `rd_en_o`, `c_we_o` and all pipeline valid bits clear on the next edge.
  - No `done_o` pulse; already-written results are left in place.
  - `abort_i` in IDLE or DONE has no effect.
- Simultaneous events:
  - `abort_i` and `start_i` in the same RUN cycle: abort wins; start is ignored.
  - `start_i` during DONE is ignored; a start is accepted from the following IDLE cycle.
- `rst_i` = 1: state IDLE; all outputs 0 (`rd_en_o`, `rd_addr_o`, `c_we_o`, `c_addr_o`, `c_data_o`, `busy_o`, `done_o`); `q_r` = 0. Reset mid-operation behaves like abort.

## Timing

- Cycle 0: `start_i` sampled high in IDLE.
- Cycles 1..N: RUN; `rd_addr_o` = cycle − 1.
- Each address is written 2 cycles after it is issued: `c_we_o` = 1 with `c_addr_o` = k in cycle k + 3.
- Writes occupy cycles 3..N+2, back to back, with no gaps.
- Cycles N+1..N+2: DRAIN. Cycle N+3: DONE, `done_o` = 1.
- `busy_o` is high for cycles 1..N+2, i.e. N+2 cycles.
- Earliest next accepted start is cycle N+4; the next operation's first read is cycle N+5.
- Throughput: one coefficient per clock.
- `rd_addr_o` holds its last value when `rd_en_o` = 0.
- `c_data_o` and `c_addr_o` are don't-care when `c_we_o` = 0.

## Test plan

- Reset, then idle: `rst_i` held 2 cycles, then released with no start → all outputs 0, state stays IDLE, no `done_o`.
- Basic vector, N=4, q=0x6D3410; A={5, 3, 7, 0xFFFFFF}, B={3, 5, 7, 0}:
  - Writes C={0x000002, 0x6D340E, 0x000000, 0x7FFFFF} to addresses 0..3 in cycles 3..6.
  - `done_o` pulses in cycle 7; `busy_o` is high in cycles 1..6.
- Wrap corner, a=0, b=0xFFFFFF, q=0x6D3410 → c=0x6D3411; a=0x800000, b=1 → c=0x7FFFFF.
- `q_i` latching: `q_i` changed to 0 after start → every result still uses 0x6D3410. A second start during RUN → ignored, exactly N writes occur.
- Abort: `abort_i` pulsed in cycle 3 of an N=8 run:
  - Only address 0 is written; `c_we_o` and `busy_o` are 0 from cycle 4; no `done_o`.
  - A new start is then accepted and completes normally.
- Back-to-back runs: start in cycle 0 and again in cycle N+4 → two complete runs of N writes each, with two `done_o` pulses N+4 cycles apart. A random-vector scoreboard checks every write against the arithmetic formula.
